// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch unit with a 4-entry instruction queue, cache miss
//            handling and branch/exception redirect support.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hit_miss,
    input  logic [31:0] data_from_cache,
    output logic [31:0] address_to_cache,
    output logic        r_w,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        MISS_WAIT = 2'd1,
        QFULL     = 2'd2
    } state_t;

    localparam logic [2:0] FULL_CNT = 3'(QDEPTH);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        discard_q, discard_d;
    logic [15:0] miss_count_q, miss_count_d;
    logic [1:0]  wptr_q, wptr_d;
    logic [1:0]  rptr_q, rptr_d;
    logic [2:0]  count_q, count_d;
    logic [31:0] qpc_q   [4];
    logic [31:0] qdata_q [4];

    logic        push;
    logic        pop;
    logic        flush;
    logic        pop_ok;
    logic [31:0] redirect_tgt;
    logic [31:0] pc_inc;

    assign pop_ok       = (count_q != 3'd0) && instr_ready;
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign pc_inc       = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        discard_d    = discard_q;
        miss_count_d = miss_count_q;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_tgt;
                end else begin
                    pop = pop_ok;
                    if (count_q == FULL_CNT) begin
                        state_d = QFULL;
                    end else if (hit_miss) begin
                        push = 1'b1;
                        pc_d = pc_inc;
                    end else begin
                        state_d = MISS_WAIT;
                        if (miss_count_q != 16'hFFFF) begin
                            miss_count_d = miss_count_q + 16'd1;
                        end
                    end
                end
            end
            MISS_WAIT: begin
                // A redirect arriving together with the refill completes at once.
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (hit_miss) begin
                        pc_d      = redirect_tgt;
                        discard_d = 1'b0;
                        state_d   = FETCH;
                    end else begin
                        pend_pc_d = redirect_tgt;
                        discard_d = 1'b1;
                    end
                end else begin
                    pop = pop_ok;
                    if (hit_miss) begin
                        if (discard_q) begin
                            pc_d = pend_pc_q;
                        end else begin
                            push = 1'b1;
                            pc_d = pc_inc;
                        end
                        discard_d = 1'b0;
                        state_d   = FETCH;
                    end
                end
            end
            QFULL: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else begin
                    pop = pop_ok;
                    if (count_q != FULL_CNT) begin
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = 2'd0;
            rptr_d  = 2'd0;
            count_d = 3'd0;
        end else begin
            wptr_d  = wptr_q + {1'b0, push};
            rptr_d  = rptr_q + {1'b0, pop};
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pend_pc_q    <= 32'h0000_0000;
            discard_q    <= 1'b0;
            miss_count_q <= 16'h0000;
            wptr_q       <= 2'd0;
            rptr_q       <= 2'd0;
            count_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            discard_q    <= discard_d;
            miss_count_q <= miss_count_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            qpc_q[wptr_q]   <= pc_q;
            qdata_q[wptr_q] <= data_from_cache;
        end
    end

    assign address_to_cache = pc_q;
    assign r_w              = 1'b0;
    assign instr_valid      = (count_q != 3'd0);
    assign instr_data       = qdata_q[rptr_q];
    assign instr_pc         = qpc_q[rptr_q];
    assign miss_count       = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Self-checking bench for instr_fetch against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_FULL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hit_miss = 1'b0;
    logic [31:0] data_from_cache = '0;
    logic [31:0] address_to_cache;
    logic        r_w;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [15:0] miss_count;

    instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .hit_miss         (hit_miss),
        .data_from_cache  (data_from_cache),
        .address_to_cache (address_to_cache),
        .r_w              (r_w),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_ready      (instr_ready),
        .instr_valid      (instr_valid),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .miss_count       (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc = '0;
    logic [31:0] mpend = '0;
    logic        mdisc = 1'b0;
    logic [15:0] mmiss = '0;
    int          mmode = M_RUN;
    bit          armed = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: one call per rising edge, using the inputs held across it.
    task automatic model_step();
        int          sz;
        bit          do_pop;
        logic [31:0] tgt;
        ent_t        e;
        sz     = mq.size();
        do_pop = instr_ready && (sz != 0);
        tgt    = redirect_pc & ~32'h3;
        if (!reset) begin
            mpc = RESET_PC; mpend = '0; mdisc = 1'b0; mmiss = '0;
            mmode = M_RUN; mq.delete(); armed = 1'b1;
        end else if (redirect_valid) begin
            mq.delete();
            if (mmode == M_WAIT && !hit_miss) begin
                mpend = tgt; mdisc = 1'b1;
            end else begin
                mpc = tgt; mdisc = 1'b0; mmode = M_RUN;
            end
        end else begin
            if (do_pop) void'(mq.pop_front());
            e.pc   = mpc;
            e.data = data_from_cache;
            if (mmode == M_WAIT) begin
                if (hit_miss) begin
                    if (mdisc) mpc = mpend;
                    else begin mq.push_back(e); mpc = mpc + 32'd4; end
                    mdisc = 1'b0;
                    mmode = M_RUN;
                end
            end else if (mmode == M_FULL) begin
                if (sz < 4) mmode = M_RUN;
            end else begin
                if (sz == 4) mmode = M_FULL;
                else if (hit_miss) begin mq.push_back(e); mpc = mpc + 32'd4; end
                else begin
                    mmode = M_WAIT;
                    if (mmiss != 16'hFFFF) mmiss = mmiss + 16'd1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("address", address_to_cache, mpc);
            chk("r_w", {31'd0, r_w}, 32'd0);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
            chk("miss_count", {16'd0, miss_count}, {16'd0, mmiss});
            if (mq.size() != 0) begin
                chk("instr_pc", instr_pc, mq[0].pc);
                chk("instr_data", instr_data, mq[0].data);
            end
        end
    end

    task automatic cyc(input logic rst, input logic hit, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
        reset           = rst;
        hit_miss        = hit;
        data_from_cache = $urandom;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        instr_ready     = rdy;
        @(negedge clk);
    endtask

    task automatic hits(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        // Scenario 1: streaming hits
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
        chk("rst_addr", address_to_cache, 32'h0000_0000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_miss", {16'd0, miss_count}, 32'd0);
        hits(1, 1'b1);
        chk("s1_addr1", address_to_cache, 32'h4);
        chk("s1_pc1", instr_pc, 32'h0);
        hits(2, 1'b1);
        chk("s1_addr3", address_to_cache, 32'hC);
        chk("s1_pc3", instr_pc, 32'h8);

        // Scenario 2: miss at 0x10 held for five cycles
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        hits(4, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("s2_addr", address_to_cache, 32'h10);
        chk("s2_miss", {16'd0, miss_count}, 32'd1);
        hits(1, 1'b1);
        chk("s2_addr_after", address_to_cache, 32'h14);
        chk("s2_head", instr_pc, 32'h10);

        // Scenario 3: consumer stalled until the queue fills
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        hits(8, 1'b0);
        chk("s3_addr_full", address_to_cache, 32'h10);
        chk("s3_head", instr_pc, 32'h0);
        hits(1, 1'b1);
        chk("s3_head_pop", instr_pc, 32'h4);
        hits(1, 1'b0);
        chk("s3_addr_hold", address_to_cache, 32'h10);
        hits(1, 1'b0);
        chk("s3_addr_resume", address_to_cache, 32'h14);

        // Scenario 4: redirect while a miss is outstanding
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        hits(16, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0203, 1'b1);
        chk("s4_addr_hold", address_to_cache, 32'h40);
        chk("s4_flushed", {31'd0, instr_valid}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("s4_addr_hold2", address_to_cache, 32'h40);
        hits(1, 1'b0);
        chk("s4_addr_tgt", address_to_cache, 32'h200);
        chk("s4_empty", {31'd0, instr_valid}, 32'd0);
        chk("s4_miss", {16'd0, miss_count}, 32'd1);

        // Scenario 5: redirect to the top of the address space
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("s5_addr_top", address_to_cache, 32'hFFFF_FFFC);
        hits(1, 1'b0);
        chk("s5_addr_wrap", address_to_cache, 32'h0);
        chk("s5_head", instr_pc, 32'hFFFF_FFFC);

        // Scenario 6: reset during a miss with entries queued
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        hits(3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b0);
        chk("s6_valid", {31'd0, instr_valid}, 32'd0);
        chk("s6_addr", address_to_cache, RESET_PC);
        chk("s6_miss", {16'd0, miss_count}, 32'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 15) == 0,
                ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom,
                $urandom_range(0, 9) < 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
